// File: rtl/ps2_key_event_ctrl_pkg.sv
// ps2_key_event_ctrl_pkg: scan-code prefixes, read FSM encoding and event record
package ps2_key_event_ctrl_pkg;
    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
    typedef enum logic {RD_IDLE = 1'b0, RD_POP = 1'b1} rd_state_t;
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rep;
    } key_evt_t;
endpackage

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: pops the ps2_keyboard FIFO, folds E0/F0 prefixes into key events,
// tracks the held key, counts new presses and offers events on a valid/ready port.
module ps2_key_event_ctrl
    import ps2_key_event_ctrl_pkg::*;
#(
    parameter int CNT_W           = 8,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       kb_data,
    input  logic             kb_ready,
    output logic             kb_nextdata_n,
    input  logic             kb_overflow,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             evt_repeat,
    output logic             key_held,
    output logic [7:0]       held_code,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_flag
);
    rd_state_t        rd_q, rd_d;
    logic [7:0]       byte_q, byte_d;
    logic             nd_n_q, nd_n_d;
    logic             pfx_ext_q, pfx_ext_d, pfx_brk_q, pfx_brk_d;
    key_evt_t         evt_q, evt_d;
    logic             evt_valid_q, evt_valid_d;
    logic [8:0]       held_q, held_d;
    logic             key_held_q, key_held_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             apply, is_ext, is_brk, is_evt, match, rep, new_make, emit;

    always_comb begin
        apply    = rd_q == RD_POP;
        is_ext   = byte_q == PS2_PFX_EXT;
        is_brk   = byte_q == PS2_PFX_BRK;
        is_evt   = apply && !is_ext && !is_brk;
        match    = key_held_q && held_q == {byte_q, pfx_ext_q};
        rep      = is_evt && !pfx_brk_q && match;
        new_make = is_evt && !pfx_brk_q && !match;
        emit     = is_evt && !(rep && SUPPRESS_REPEAT);
        // Stalling while an event is parked guarantees the slot is free at the pop exit edge.
        rd_d        = apply ? RD_IDLE
                    : (kb_ready && !(evt_valid_q && !evt_ready)) ? RD_POP : RD_IDLE;
        byte_d      = (!apply && rd_d == RD_POP) ? kb_data : byte_q;
        nd_n_d      = rd_d != RD_POP;
        pfx_ext_d   = apply ? (is_ext || (is_brk && pfx_ext_q)) : pfx_ext_q;
        pfx_brk_d   = apply ? (is_brk || (is_ext && pfx_brk_q)) : pfx_brk_q;
        evt_valid_d = emit || (evt_valid_q && !evt_ready);
        evt_d       = emit ? {byte_q, pfx_ext_q, pfx_brk_q, rep} : evt_q;
        held_d      = new_make ? {byte_q, pfx_ext_q} : held_q;
        key_held_d  = is_evt ? (pfx_brk_q ? key_held_q && !match : 1'b1) : key_held_q;
        cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, new_make};
        ovf_d       = ovf_q || kb_overflow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q        <= RD_IDLE;
            byte_q      <= '0;
            nd_n_q      <= 1'b1;
            pfx_ext_q   <= 1'b0;
            pfx_brk_q   <= 1'b0;
            evt_q       <= '0;
            evt_valid_q <= 1'b0;
            held_q      <= '0;
            key_held_q  <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            rd_q        <= rd_d;
            byte_q      <= byte_d;
            nd_n_q      <= nd_n_d;
            pfx_ext_q   <= pfx_ext_d;
            pfx_brk_q   <= pfx_brk_d;
            evt_q       <= evt_d;
            evt_valid_q <= evt_valid_d;
            held_q      <= held_d;
            key_held_q  <= key_held_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    assign kb_nextdata_n = nd_n_q;
    assign evt_valid     = evt_valid_q;
    assign evt_code      = evt_q.code;
    assign evt_ext       = evt_q.ext;
    assign evt_break     = evt_q.brk;
    assign evt_repeat    = evt_q.rep;
    assign key_held      = key_held_q;
    assign held_code     = held_q[8:1];
    assign press_cnt     = cnt_q;
    assign ovf_flag      = ovf_q;
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl: FIFO models feed two controllers (repeat suppressed / emitted);
// expected events go into queues that per-instance monitors pop at each handshake.
module tb_ps2_key_event_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] kb_data0, kb_data1, code0, code1, held0, held1;
    logic       kb_ready0, kb_ready1, nd0, nd1, kb_ovf;
    logic       ev0, ev1, ext0, ext1, brk0, brk1, rep0, rep1, kh0, kh1, ovf0, ovf1;
    logic       rdy0, rdy1;
    logic [7:0] cnt0, cnt1;
    logic [7:0] fifo0[$], fifo1[$];
    logic [10:0] exp0[$], exp1[$];
    int n_tests = 0, n_fail = 0, pops0 = 0, pops1 = 0, run0 = 0, maxrun0 = 0;

    ps2_key_event_ctrl #(.CNT_W(8), .SUPPRESS_REPEAT(1'b1)) dut0 (
        .clk(clk), .rst(rst), .kb_data(kb_data0), .kb_ready(kb_ready0), .kb_nextdata_n(nd0),
        .kb_overflow(kb_ovf), .evt_valid(ev0), .evt_ready(rdy0), .evt_code(code0), .evt_ext(ext0),
        .evt_break(brk0), .evt_repeat(rep0), .key_held(kh0), .held_code(held0), .press_cnt(cnt0),
        .ovf_flag(ovf0));
    ps2_key_event_ctrl #(.CNT_W(8), .SUPPRESS_REPEAT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .kb_data(kb_data1), .kb_ready(kb_ready1), .kb_nextdata_n(nd1),
        .kb_overflow(kb_ovf), .evt_valid(ev1), .evt_ready(rdy1), .evt_code(code1), .evt_ext(ext1),
        .evt_break(brk1), .evt_repeat(rep1), .key_held(kh1), .held_code(held1), .press_cnt(cnt1),
        .ovf_flag(ovf1));

    // FIFO models: pop on each low cycle of kb_nextdata_n, refresh head half a cycle later
    always @(negedge clk) begin
        if (!nd0) begin
            run0++;
            pops0++;
            if (fifo0.size() != 0) void'(fifo0.pop_front());
        end else run0 = 0;
        if (run0 > maxrun0) maxrun0 = run0;
        kb_ready0 = fifo0.size() != 0;
        kb_data0  = fifo0.size() != 0 ? fifo0[0] : 8'h00;
        if (!nd1) begin
            pops1++;
            if (fifo1.size() != 0) void'(fifo1.pop_front());
        end
        kb_ready1 = fifo1.size() != 0;
        kb_data1  = fifo1.size() != 0 ? fifo1[0] : 8'h00;
    end

    always @(negedge clk) begin
        logic [10:0] e;
        if (!rst && ev0 && rdy0) begin
            n_tests++;
            if (exp0.size() == 0) begin
                n_fail++;
                $display("FAIL evt0 unexpected event got %h", {code0, ext0, brk0, rep0});
            end else begin
                e = exp0.pop_front();
                if ({code0, ext0, brk0, rep0} !== e) begin
                    n_fail++;
                    $display("FAIL evt0 got %h exp %h", {code0, ext0, brk0, rep0}, e);
                end
            end
        end
        if (!rst && ev1 && rdy1) begin
            n_tests++;
            if (exp1.size() == 0) begin
                n_fail++;
                $display("FAIL evt1 unexpected event got %h", {code1, ext1, brk1, rep1});
            end else begin
                e = exp1.pop_front();
                if ({code1, ext1, brk1, rep1} !== e) begin
                    n_fail++;
                    $display("FAIL evt1 got %h exp %h", {code1, ext1, brk1, rep1}, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        exp0.delete();
        exp1.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((fifo0.size() + fifo1.size() + exp0.size() + exp1.size()) != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        if (t >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain timeout exp0=%0d exp1=%0d left", exp0.size(), exp1.size());
            exp0.delete();
            exp1.delete();
        end
    endtask

    task automatic push0(input logic [7:0] b);
        fifo0.push_back(b);
    endtask

    task automatic expect0(input logic [7:0] c, input logic x, input logic b, input logic r);
        exp0.push_back({c, x, b, r});
    endtask

    initial begin
        int p;
        logic [7:0] b;
        rdy0 = 1'b1; rdy1 = 1'b1; kb_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_nextdata_n", 16'(nd0), 16'h1);
        check("rst_evt_valid", 16'(ev0), 16'h0);
        check("rst_fields", {code0, ext0, brk0, rep0, kh0}, 16'h0);
        check("rst_held_cnt", {held0, cnt0}, 16'h0);
        check("rst_ovf", 16'(ovf0), 16'h0);
        rst = 1'b0;

        p = pops0;
        push0(8'h1C); expect0(8'h1C, 0, 0, 0);
        drain();
        check("single_pops", 16'(pops0 - p), 16'h1);
        check("single_cnt", 16'(cnt0), 16'h1);
        check("single_held", {7'h0, kh0, held0}, 16'h011C);

        do_reset();
        p = pops0;
        push0(8'h1C); push0(8'hF0); push0(8'h1C);
        expect0(8'h1C, 0, 0, 0); expect0(8'h1C, 0, 1, 0);
        drain();
        check("mkbrk_pops", 16'(pops0 - p), 16'h3);
        check("mkbrk_held", 16'(kh0), 16'h0);
        check("mkbrk_cnt", 16'(cnt0), 16'h1);

        do_reset();
        push0(8'hE0); push0(8'h75); push0(8'hE0); push0(8'hF0); push0(8'h75);
        expect0(8'h75, 1, 0, 0); expect0(8'h75, 1, 1, 0);
        drain();
        check("ext_held", 16'(kh0), 16'h0);
        check("ext_cnt", 16'(cnt0), 16'h1);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            push0(8'h1C);
            fifo1.push_back(8'h1C);
            exp1.push_back({8'h1C, 1'b0, 1'b0, i != 0});
        end
        expect0(8'h1C, 0, 0, 0);
        drain();
        check("rep_sup_cnt", 16'(cnt0), 16'h1);
        check("rep_emit_cnt", 16'(cnt1), 16'h1);
        check("rep_emit_held", {7'h0, kh1, held1}, 16'h011C);

        do_reset();
        @(posedge clk); #1 rdy0 = 1'b0;
        p = pops0;
        push0(8'h16); push0(8'h1E);
        expect0(8'h16, 0, 0, 0); expect0(8'h1E, 0, 0, 0);
        repeat (20) @(posedge clk);
        #1;
        check("bp_pops", 16'(pops0 - p), 16'h1);
        check("bp_hold", {7'h0, ev0, code0}, 16'h0116);
        rdy0 = 1'b1;
        @(posedge clk); #1 rdy0 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("bp_next", {7'h0, ev0, code0}, 16'h011E);
        check("bp_pops2", 16'(pops0 - p), 16'h2);
        rdy0 = 1'b1;
        drain();
        check("bp_cnt", 16'(cnt0), 16'h2);

        do_reset();
        push0(8'hE0);
        drain();
        do_reset();
        push0(8'h75); expect0(8'h75, 0, 0, 0);
        drain();
        check("rstpfx_cnt", 16'(cnt0), 16'h1);

        do_reset();
        for (int i = 0; i < 255; i++) begin
            b = i[0] ? 8'h11 : 8'h10;
            push0(b); expect0(b, 0, 0, 0);
        end
        drain();
        check("cnt_ff", 16'(cnt0), 16'h00FF);
        push0(8'h12); expect0(8'h12, 0, 0, 0);
        drain();
        check("cnt_wrap", 16'(cnt0), 16'h0000);
        check("wrap_held", 16'(held0), 16'h0012);

        check("ovf_pre", 16'(ovf0), 16'h0);
        @(posedge clk); #1 kb_ovf = 1'b1;
        @(posedge clk); #1 kb_ovf = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("ovf_sticky", {ovf0, ovf1}, 16'h3);
        check("nextdata_pulse", 16'(maxrun0), 16'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
